// File: rtl/adc_cap_pkg.sv
// Shared types and sizing helpers for the ADC capture engine.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

  // Buffer depth in words for a given address width.
  function automatic int unsigned cap_depth(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  // Pretrigger words retained ahead of the trigger word.
  function automatic int unsigned cap_pre(input int unsigned depth, input int unsigned post);
    return depth - post;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl.sv
// Circular-buffer capture engine: pretrigger fill, arm, post-trigger count,
// then freeze and report per-channel done bits and the oldest-word address.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int unsigned NCHAN        = 8,
  parameter int unsigned SAMPLE_BITS  = 128,
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned POST_SAMPLES = 3072  // legal range 1..2**ADDR_BITS
) (
  input  logic                         adc_div2_clk,
  input  logic                         rst,
  input  logic                         capture_i,
  input  logic                         clear_i,
  input  logic [NCHAN-1:0]             chan_en_i,
  input  logic [NCHAN*SAMPLE_BITS-1:0] adc_dat_i,
  output logic [NCHAN*SAMPLE_BITS-1:0] bram_dat_o,
  output logic [ADDR_BITS-1:0]         bram_addr_o,
  output logic [NCHAN-1:0]             bram_we_o,
  output logic [NCHAN-1:0]             done_o,
  output logic [ADDR_BITS-1:0]         start_addr_o,
  output logic                         busy_o
);

  localparam int unsigned DEPTH = cap_depth(ADDR_BITS);
  localparam int unsigned PRE   = cap_pre(DEPTH, POST_SAMPLES);
  localparam logic [ADDR_BITS:0] PRE_CNT  = PRE[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] POST_CNT = POST_SAMPLES[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  cap_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [ADDR_BITS:0]   fill_cnt_q;
  logic [ADDR_BITS:0]   post_cnt_q;
  logic [NCHAN-1:0]     mask_q;
  logic [NCHAN-1:0]     mask_eff;
  logic                 wr_en;
  logic                 trig;

  // State register.
  always_ff @(posedge adc_div2_clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state, write strobe, trigger strobe and the mask applied to this cycle's write.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    trig     = 1'b0;
    mask_eff = mask_q;
    unique case (state_q)
      FILL: begin
        mask_eff = chan_en_i;
        // fill_cnt only equals PRE on entry when PRE is zero: arm without writing.
        if (fill_cnt_q == PRE_CNT) begin
          state_d = ARMED;
        end else begin
          wr_en = 1'b1;
          if (fill_cnt_q + CNT_ONE == PRE_CNT) state_d = ARMED;
        end
      end
      ARMED: begin
        mask_eff = chan_en_i;
        wr_en    = 1'b1;
        if (capture_i) begin
          trig    = 1'b1;
          state_d = (POST_SAMPLES == 1) ? DONE : POST;
        end
      end
      POST: begin
        wr_en = 1'b1;
        if (post_cnt_q + CNT_ONE == POST_CNT) state_d = DONE;
      end
      DONE: begin
      end
      default: begin
      end
    endcase
    // Clear overrides everything in the cycle it is seen, including a capture.
    if (clear_i) begin
      state_d = FILL;
      wr_en   = 1'b0;
      trig    = 1'b0;
    end
  end

  // Write datapath, counters, mask freeze and status outputs.
  always_ff @(posedge adc_div2_clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      fill_cnt_q   <= '0;
      post_cnt_q   <= '0;
      mask_q       <= '0;
      bram_dat_o   <= '0;
      bram_addr_o  <= '0;
      bram_we_o    <= '0;
      done_o       <= '0;
      start_addr_o <= '0;
      busy_o       <= 1'b0;
    end else begin
      bram_we_o <= wr_en ? mask_eff : '0;
      if (wr_en) begin
        bram_dat_o  <= adc_dat_i;
        bram_addr_o <= wr_addr_q;
      end
      if (state_q == FILL || state_q == ARMED) mask_q <= chan_en_i;
      if (clear_i) begin
        wr_addr_q    <= '0;
        fill_cnt_q   <= '0;
        post_cnt_q   <= '0;
        done_o       <= '0;
        start_addr_o <= '0;
        busy_o       <= 1'b1;
      end else begin
        if (wr_en) wr_addr_q <= wr_addr_q + 1'b1;
        if (wr_en && state_q == FILL) fill_cnt_q <= fill_cnt_q + CNT_ONE;
        if (trig)                           post_cnt_q <= CNT_ONE;
        else if (wr_en && state_q == POST)  post_cnt_q <= post_cnt_q + CNT_ONE;
        // On entry to DONE the address after the last write is T+POST_SAMPLES.
        if (state_d == DONE && state_q != DONE) begin
          done_o       <= mask_eff;
          start_addr_o <= wr_addr_q + 1'b1;
        end
        busy_o <= (state_d != DONE);
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: three instances (POST_SAMPLES 10, 16, 1)
// share one stimulus stream; each has its own reference model and monitor.
module tb_adc_capture_ctrl;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned SB    = 128;
  localparam int unsigned AB    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NI    = 3;
  localparam int unsigned W     = NCHAN * SB;

  logic             clk = 1'b0;
  logic             rst;
  logic             capture;
  logic             clear;
  logic [NCHAN-1:0] chan_en;
  logic [W-1:0]     adc_dat;
  int unsigned      dcnt;

  logic [W-1:0]       dat_o   [NI];
  logic [AB-1:0]      addr_o  [NI];
  logic [NCHAN-1:0]   we_o    [NI];
  logic [NCHAN-1:0]   done_o  [NI];
  logic [AB-1:0]      start_o [NI];
  logic               busy_o  [NI];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [SB-1:0] slice_of(input int unsigned cnt, input int unsigned ch);
    logic [SB-1:0] v;
    v = (SB'(cnt) << 8) | SB'(ch);
    return v;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic drive_dat();
    for (int unsigned c = 0; c < NCHAN; c++) adc_dat[c*SB +: SB] = slice_of(dcnt, c);
  endtask

  task automatic cyc(input bit cap, input bit clr, input logic [NCHAN-1:0] en, input bit rs);
    capture = cap;
    clear   = clr;
    chan_en = en;
    rst     = rs;
    @(posedge clk);
    #1;
    dcnt++;
    drive_dat();
    capture = 1'b0;
    clear   = 1'b0;
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned P   = (g == 0) ? 10 : (g == 1) ? 16 : 1;
    localparam int unsigned PRE = DEPTH - P;

    adc_capture_ctrl #(
      .NCHAN(NCHAN), .SAMPLE_BITS(SB), .ADDR_BITS(AB), .POST_SAMPLES(P)
    ) dut (
      .adc_div2_clk(clk), .rst(rst), .capture_i(capture), .clear_i(clear),
      .chan_en_i(chan_en), .adc_dat_i(adc_dat), .bram_dat_o(dat_o[g]),
      .bram_addr_o(addr_o[g]), .bram_we_o(we_o[g]), .done_o(done_o[g]),
      .start_addr_o(start_o[g]), .busy_o(busy_o[g])
    );

    typedef struct { logic [AB-1:0] addr; logic [W-1:0] dat; logic [NCHAN-1:0] we; } wr_t;
    typedef struct { logic [NCHAN-1:0] we; logic [NCHAN-1:0] done; logic [AB-1:0] start; logic busy; } st_t;

    wr_t wq[$];
    st_t sq[$];

    // Reference model: counts of words written before/after the trigger.
    int unsigned      filled, post, waddr, ch0_run, trig_cnt;
    bit               trig, fin, warm, mem_seen;
    logic [NCHAN-1:0] mask;
    logic [AB-1:0]    start;
    logic [SB-1:0]    shadow [DEPTH];

    always @(posedge clk) begin : model
      st_t              s;
      logic [NCHAN-1:0] m;
      bit               wr;
      wr = 1'b0;
      m  = '0;
      if (rst || clear) begin
        filled = 0; post = 0; waddr = 0; ch0_run = 0;
        trig = 1'b0; fin = 1'b0; warm = 1'b0; mask = '0; start = '0;
      end else if (!fin) begin
        if (!trig && filled < PRE) begin
          wr = 1'b1; m = chan_en; filled++;
        end else if (!trig && PRE == 0 && !warm) begin
          warm = 1'b1;
        end else if (!trig) begin
          wr = 1'b1; m = chan_en;
          if (capture) begin
            trig = 1'b1; post = 1; trig_cnt = dcnt; mask = chan_en;
          end
        end else begin
          wr = 1'b1; m = mask; post++;
        end
        if (wr) begin
          if (m != '0) wq.push_back('{addr: waddr[AB-1:0], dat: adc_dat, we: m});
          ch0_run = m[0] ? ch0_run + 1 : 0;
          waddr   = (waddr + 1) % DEPTH;
          if (trig && post == P) begin
            fin   = 1'b1;
            start = waddr[AB-1:0];
          end
        end
      end
      s.we    = m;
      s.done  = fin ? mask : '0;
      s.start = fin ? start : '0;
      s.busy  = !rst && !fin;
      sq.push_back(s);
    end

    // Monitor: pops expected writes when the DUT writes, and per-cycle status.
    always @(negedge clk) begin : mon
      st_t s;
      wr_t w;
      if (we_o[g] != '0) begin
        if (wq.size() == 0) begin
          chk($sformatf("i%0d_spurious_we", g), 64'(we_o[g]), 64'd0);
        end else begin
          w = wq.pop_front();
          chk($sformatf("i%0d_addr", g), 64'(addr_o[g]), 64'(w.addr));
          chk($sformatf("i%0d_we", g), 64'(we_o[g]), 64'(w.we));
          n_chk++;
          if (dat_o[g] !== w.dat) begin
            n_fail++;
            $display("FAIL i%0d_data: ch0 got %h expected %h", g, dat_o[g][31:0], w.dat[31:0]);
          end
        end
      end
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk($sformatf("i%0d_we_cycle", g), 64'(we_o[g]), 64'(s.we));
        chk($sformatf("i%0d_done", g), 64'(done_o[g]), 64'(s.done));
        chk($sformatf("i%0d_start", g), 64'(start_o[g]), 64'(s.start));
        chk($sformatf("i%0d_busy", g), 64'(busy_o[g]), 64'(s.busy));
      end
      if (we_o[g][0]) shadow[addr_o[g]] = dat_o[g][SB-1:0];
      if (!fin) mem_seen = 1'b0;
      if (fin && !mem_seen) begin
        mem_seen = 1'b1;
        if (ch0_run >= DEPTH) begin
          for (int unsigned i = 0; i < DEPTH; i++)
            chk($sformatf("i%0d_mem%0d", g, i),
                64'(shadow[(int'(start) + i) % DEPTH]), 64'(slice_of(trig_cnt - PRE + i, 0)));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; capture = 1'b0; clear = 1'b0; chan_en = '1; dcnt = 0;
    drive_dat();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Early capture ignored in FILL; trigger at address 9 on the POST=10 instance.
    for (int k = 0; k < 23; k++) cyc(k == 3 || k == 9, 1'b0, 8'hFF, 1'b0);
    chk("d1_done0", 64'(done_o[0]), 64'hFF);
    chk("d1_start0", 64'(start_o[0]), 64'd3);
    chk("d1_we0", 64'(we_o[0]), 64'd0);
    chk("d1_busy0", 64'(busy_o[0]), 64'd0);
    chk("d1_start1", 64'(start_o[1]), 64'd2);
    chk("d1_busy2", 64'(busy_o[2]), 64'd1);

    // Mask frozen at the trigger cycle.
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int j = 1; j <= 22; j++) cyc(j == 9, 1'b0, (j == 9) ? 8'h0F : 8'hFF, 1'b0);
    chk("d2_done0", 64'(done_o[0]), 64'h0F);

    // Clear mid-POST, then a capture that completes.
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int j = 1; j <= 11; j++) cyc(j == 8, 1'b0, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int j = 1; j <= 24; j++) begin
      cyc(j == 10, 1'b0, 8'hFF, 1'b0);
      if (j == 1) begin
        chk("d3_addr_restart", 64'(addr_o[0]), 64'd0);
        chk("d3_done_after_clear", 64'(done_o[0]), 64'd0);
      end
    end
    chk("d3_done0", 64'(done_o[0]), 64'hFF);
    chk("d3_start0", 64'(start_o[0]), 64'd3);

    // Clear and capture together in ARMED: capture dropped.
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int j = 1; j <= 10; j++) cyc(1'b0, 1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int j = 1; j <= 8; j++) cyc(1'b0, 1'b0, 8'hFF, 1'b0);
    chk("d4_busy0", 64'(busy_o[0]), 64'd1);
    chk("d4_done0", 64'(done_o[0]), 64'd0);
    for (int j = 9; j <= 22; j++) cyc(j == 20, 1'b0, 8'hFF, 1'b0);
    chk("d4_done2", 64'(done_o[2]), 64'hFF);
    chk("d4_start2", 64'(start_o[2]), 64'd4);

    // Randomized traffic.
    for (int unsigned n = 0; n < 1500; n++) begin
      int unsigned r;
      logic [NCHAN-1:0] en;
      r  = $urandom_range(0, 999);
      en = ($urandom_range(0, 7) == 0) ? NCHAN'($urandom) : chan_en;
      cyc(r >= 2 && r < 50, r >= 50 && r < 66, en, r < 2);
    end
    cyc(1'b0, 1'b0, chan_en, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
